hack_alu_pipe: RTL
==================

// Module: hack_alu_pipe
// PURPOSE
//   Parametrised-width, 2-stage pipelined Hack ALU with valid/ready handshake on input and output.
//   Same zx/nx/zy/ny/f/no function set as the combinational Hack ALU, plus carry/overflow flags
//   and a completed-operation counter. Sits between the CPU operand registers and writeback,
//   so the datapath can close timing at higher clock rates and absorb writeback stalls.
// PARAMETERS
//   WIDTH   16  data width of x, y, out; legal range >= 2
//   CNT_W   32  width of op_count completed-operation counter
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand/control bundle valid
//   in_ready   out  1      block can accept bundle this cycle
//   x          in   WIDTH  data input x
//   y          in   WIDTH  data input y
//   zx,nx      in   1      zero x / bitwise-NOT x (zero applied first)
//   zy,ny      in   1      zero y / bitwise-NOT y (zero applied first)
//   f          in   1      1: x+y (mod 2^WIDTH), 0: x&y
//   no         in   1      bitwise-NOT final result
//   out_valid  out  1      result bundle valid
//   out_ready  in   1      downstream accepts result this cycle
//   out        out  WIDTH  result
//   zr         out  1      out == 0
//   ng         out  1      out[WIDTH-1]
//   cy         out  1      carry out of adder (f=1), else 0; taken before no
//   ov         out  1      signed overflow of adder (f=1), else 0; taken before no
//   op_count   out  CNT_W  number of results accepted downstream (out_valid && out_ready)
// BEHAVIOUR
//   Reset: all pipeline valids 0; out, zr, ng, cy, ov, op_count = 0; in_ready = 1 the cycle after.
//   Stage 1 (S1): on accept (in_valid && in_ready), register x_n = nx ? ~(zx?0:x) : (zx?0:x),
//     y_n likewise, plus f and no; s1_valid <= 1. Otherwise s1_valid <= 0 when S1 drains.
//   Stage 2 (S2): when S1 advances into S2: r = f ? x_n+y_n : x_n&y_n (WIDTH bits);
//     cy = f & carry-out bit WIDTH of {1'b0,x_n}+{1'b0,y_n};
//     ov = f & (x_n[MSB]==y_n[MSB]) & (sum[MSB]!=x_n[MSB]);
//     out = no ? ~r : r; zr = (out==0); ng = out[MSB]. All registered together with out_valid.
//   Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//     in_ready is combinational from out_ready and valids; no combinational path from in_valid.
//   Latency: 2 cycles accept-to-out_valid with out_ready held high; throughput 1 op/cycle.
//   Stall: while out_valid && !out_ready, out/zr/ng/cy/ov held stable; S1 fills, then in_ready=0
//     (max 2 bundles in flight). No bundle dropped, duplicated or reordered.
//   Simultaneous accept and emit in one cycle is legal and keeps full throughput.
//   When out_valid=0, data outputs hold their last value (0 after reset); consumers must gate on out_valid.
//   op_count increments on every out_valid && out_ready, wraps 2^CNT_W-1 -> 0.
//   Reset mid-operation: in-flight bundles discarded, no output handshake for them, counter cleared.
//   rst has priority over every handshake in the same cycle.
// TESTING
//   Reset: assert rst 2 cycles -> out_valid=0, in_ready=1, out=0, op_count=0.
//   Add: x=5,y=3,f=1 others 0, out_ready=1 -> 2 cycles later out=0x0008, zr=ng=cy=ov=0.
//   Flags: x=0xFFFF,y=1,f=1 -> out=0x0000 zr=1 cy=1 ov=0; x=0x7FFF,y=1 -> out=0x8000 ng=1 ov=1 cy=0.
//   Hack table: x=0x0007,y=0x0003, 18 Hack comp codes (e.g. 010011 x-y -> 0x0004, 000111 y-x -> 0xFFFC).
//   Backpressure: out_ready=0, offer 4 ops -> 2 accepted, in_ready=0, out held; release -> 4 in order, op_count=4.
//   Reset mid-flight: 2 ops in flight, pulse rst -> no out_valid for them, op_count=0; WIDTH=8: 0x80+0x80 -> 0x00 zr=1 cy=1 ov=1.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready on both sides.
// Stage 1 registers the zero/negate-preconditioned operands; stage 2 registers the result and flags.
module hack_alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_x_q, s1_y_q;
  logic             s1_f_q, s1_no_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zr_q, ng_q, cy_q, ov_q;
  logic [CNT_W-1:0] count_q;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] x_z, x_n, y_z, y_n;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] r, res;
  logic             cy_d, ov_d;

  // Ready depends only on out_ready and internal valids, never on in_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    x_z     = zx ? '0 : x;
    x_n     = nx ? ~x_z : x_z;
    y_z     = zy ? '0 : y;
    y_n     = ny ? ~y_z : y_z;
    sum_ext = {1'b0, s1_x_q} + {1'b0, s1_y_q};
    r       = s1_f_q ? sum_ext[WIDTH-1:0] : (s1_x_q & s1_y_q);
    res     = s1_no_q ? ~r : r;
    // Flags describe the adder itself, so they are taken before the final negation.
    cy_d    = s1_f_q & sum_ext[WIDTH];
    ov_d    = s1_f_q & (s1_x_q[WIDTH-1] == s1_y_q[WIDTH-1])
                     & (sum_ext[WIDTH-1] != s1_x_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_x_q  <= x_n;
      s1_y_q  <= y_n;
      s1_f_q  <= f;
      s1_no_q <= no;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      cy_q       <= 1'b0;
      ov_q       <= 1'b0;
      count_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q <= res;
          zr_q  <= (res == '0);
          ng_q  <= res[WIDTH-1];
          cy_q  <= cy_d;
          ov_q  <= ov_d;
        end
      end
      if (s2_valid_q && out_ready) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cy        = cy_q;
  assign ov        = ov_q;
  assign op_count  = count_q;

endmodule
